// File: rtl/fifo_rr_ctrl.sv
// fifo_rr_ctrl: FIFO bank controller - one-hot state broadcast, threshold distribution, round-robin pop arbitration
// Ports: clk, reset (async, active-high), init (config request), sup_th_in/inf_th_in (thresholds to load),
//   empty (per-FIFO empty flags), ds_alm_full (downstream backpressure) ->
//   state (one-hot RESET/INIT/IDLE/ACTIVE), sup_Threshold/inf_Threshold (registered thresholds),
//   pop (combinational one-hot pop), sel (registered index of last pop), valid_out (registered data-valid),
//   idle (state is IDLE), cfg_error (sticky illegal-threshold flag).
// Optional: define FIFO_RR_CTRL_BURST_EN to let a grantee hold the grant for up to 4 consecutive pops.
module fifo_rr_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = 2,
  parameter int TH_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [TH_W-1:0]    sup_th_in,
  input  logic [TH_W-1:0]    inf_th_in,
  input  logic [NUM_REQ-1:0] empty,
  input  logic               ds_alm_full,
  output logic [3:0]         state,
  output logic [TH_W-1:0]    sup_Threshold,
  output logic [TH_W-1:0]    inf_Threshold,
  output logic [NUM_REQ-1:0] pop,
  output logic [IDX_W-1:0]   sel,
  output logic               valid_out,
  output logic               idle,
  output logic               cfg_error
);
  typedef enum logic [3:0] {
    S_RST  = 4'b0001,
    S_INIT = 4'b0010,
    S_IDLE = 4'b0100,
    S_ACT  = 4'b1000
  } state_t;
  state_t st, nxt;
  logic [IDX_W-1:0] ptr, g, ix;
  logic found, grant;
  assign state = st;
  assign idle = st == S_IDLE;
  assign grant = st == S_ACT && !init && !ds_alm_full;
  always_comb begin
    nxt = S_RST;
    case (st)
      S_RST:  nxt = S_INIT;
      S_INIT: nxt = init ? S_INIT : S_IDLE;
      S_IDLE: nxt = init ? S_INIT : (&empty ? S_IDLE : S_ACT);
      S_ACT:  nxt = init ? S_INIT : (&empty ? S_IDLE : S_ACT);
      default: nxt = S_RST;
    endcase
  end
`ifdef FIFO_RR_CTRL_BURST_EN
  logic [1:0] bcnt;
  logic hold;
  // A burst continues only if the previous cycle popped this grantee, fewer than 4 pops are done, and it still has data.
  assign hold = valid_out && bcnt != 2'd3 && !empty[ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) bcnt <= '0;
    else if (st == S_INIT) bcnt <= '0;
    else if (|pop) bcnt <= hold ? bcnt + 2'd1 : 2'd0;
`endif
  always_comb begin
    g = ptr;
    ix = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      ix = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && !empty[ix]) begin
        g = ix;
        found = 1'b1;
      end
    end
`ifdef FIFO_RR_CTRL_BURST_EN
    if (hold) begin
      g = ptr;
      found = 1'b1;
    end
`endif
    pop = (grant && found) ? NUM_REQ'(1) << g : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= S_RST;
      sup_Threshold <= '0;
      inf_Threshold <= '0;
      sel <= '0;
      valid_out <= 1'b0;
      cfg_error <= 1'b0;
      ptr <= IDX_W'(NUM_REQ - 1);
    end else begin
      st <= nxt;
      if (st == S_INIT) begin
        sup_Threshold <= sup_th_in;
        inf_Threshold <= inf_th_in;
      end
      if (st != S_INIT && nxt == S_INIT) cfg_error <= 1'b0;
      else if (st == S_INIT && !init && sup_th_in <= inf_th_in) cfg_error <= 1'b1;
      valid_out <= |pop;
      if (|pop) begin
        sel <= g;
        ptr <= g;
      end
    end
endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// tb_fifo_rr_ctrl: table-driven directed test of fifo_rr_ctrl
module tb_fifo_rr_ctrl;
  logic clk = 0, reset = 1, init = 0, ds_alm_full = 0;
  logic [2:0] sup_th_in = 0, inf_th_in = 0, sup_Threshold, inf_Threshold;
  logic [3:0] empty = 4'hF, state, pop;
  logic [1:0] sel;
  logic valid_out, idle, cfg_error;
  int errors = 0, checks = 0;
  typedef struct {
    logic r, i;
    logic [2:0] sp, ip;
    logic [3:0] e;
    logic d;
    logic [3:0] st, pop;
    logic [1:0] sel;
    logic v, idl, cfg;
    logic [2:0] sth, ith;
  } vec_t;
  vec_t q[$];
  fifo_rr_ctrl #(.NUM_REQ(4), .IDX_W(2), .TH_W(3)) dut (
    .clk(clk), .reset(reset), .init(init), .sup_th_in(sup_th_in), .inf_th_in(inf_th_in),
    .empty(empty), .ds_alm_full(ds_alm_full), .state(state), .sup_Threshold(sup_Threshold),
    .inf_Threshold(inf_Threshold), .pop(pop), .sel(sel), .valid_out(valid_out), .idle(idle),
    .cfg_error(cfg_error)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, i, input logic [2:0] sp, ip, input logic [3:0] e, input logic d,
                     input logic [3:0] st, pp, input logic [1:0] sl, input logic v, idl, cfg,
                     input logic [2:0] sth, ith);
    vec_t t;
    t.r = r; t.i = i; t.sp = sp; t.ip = ip; t.e = e; t.d = d;
    t.st = st; t.pop = pp; t.sel = sl; t.v = v; t.idl = idl; t.cfg = cfg; t.sth = sth; t.ith = ith;
    q.push_back(t);
  endtask
  task automatic chk(input string n, input int k, input logic [3:0] a, input logic [3:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s vec%0d: got %b expected %b", n, k, a, b);
    end
  endtask
  initial begin
    //   r  i  sp ip e      d  st      pop     sel v  idl cfg sth ith
    add(1, 0, 0, 0, 4'hF, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 4'hF, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 4'hF, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 6, 2, 4'hF, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 6, 2, 4'hF, 0, 4'b0010, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 0, 6, 2, 4'hF, 0, 4'b0010, 4'b0000, 0, 0, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'hF, 0, 4'b0100, 4'b0000, 0, 0, 1, 0, 6, 2);
    add(0, 1, 2, 5, 4'hF, 0, 4'b0100, 4'b0000, 0, 0, 1, 0, 6, 2);
    add(0, 0, 2, 5, 4'hF, 0, 4'b0010, 4'b0000, 0, 0, 0, 0, 6, 2);
    add(0, 0, 2, 5, 4'hF, 0, 4'b0100, 4'b0000, 0, 0, 1, 1, 2, 5);
    add(0, 1, 6, 2, 4'hF, 0, 4'b0100, 4'b0000, 0, 0, 1, 1, 2, 5);
    add(0, 0, 6, 2, 4'hF, 0, 4'b0010, 4'b0000, 0, 0, 0, 0, 2, 5);
    add(0, 0, 6, 2, 4'h0, 0, 4'b0100, 4'b0000, 0, 0, 1, 0, 6, 2);
`ifdef FIFO_RR_CTRL_BURST_EN
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0001, 0, 0, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0001, 0, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0001, 0, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0001, 0, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0010, 0, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0010, 1, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0010, 1, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0010, 1, 1, 0, 0, 6, 2);
`else
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0001, 0, 0, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0010, 0, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0100, 1, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b1000, 2, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0001, 3, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0010, 0, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0100, 1, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b1000, 2, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0001, 3, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0010, 0, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'hB, 0, 4'b1000, 4'b0100, 1, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'hE, 0, 4'b1000, 4'b0001, 2, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 1, 4'b1000, 4'b0000, 0, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 1, 4'b1000, 4'b0000, 0, 0, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 1, 4'b1000, 4'b0000, 0, 0, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0010, 0, 0, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'hF, 0, 4'b1000, 4'b0000, 1, 1, 0, 0, 6, 2);
    add(0, 0, 6, 2, 4'hF, 0, 4'b0100, 4'b0000, 1, 0, 1, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b0100, 4'b0000, 1, 0, 1, 0, 6, 2);
    add(0, 0, 6, 2, 4'h0, 0, 4'b1000, 4'b0100, 1, 0, 0, 0, 6, 2);
`endif
    foreach (q[k]) begin
      @(negedge clk);
      reset = q[k].r; init = q[k].i; sup_th_in = q[k].sp; inf_th_in = q[k].ip;
      empty = q[k].e; ds_alm_full = q[k].d;
      #1;
      chk("state", k, state, q[k].st);
      chk("pop", k, pop, q[k].pop);
      chk("sel", k, {2'b00, sel}, {2'b00, q[k].sel});
      chk("valid_out", k, {3'b000, valid_out}, {3'b000, q[k].v});
      chk("idle", k, {3'b000, idle}, {3'b000, q[k].idl});
      chk("cfg_error", k, {3'b000, cfg_error}, {3'b000, q[k].cfg});
      chk("sup_Threshold", k, {1'b0, sup_Threshold}, {1'b0, q[k].sth});
      chk("inf_Threshold", k, {1'b0, inf_Threshold}, {1'b0, q[k].ith});
    end
    @(negedge clk);
    #1;
    chk("pre_async_state", 99, state, 4'b1000);
    chk("pre_async_valid", 99, {3'b000, valid_out}, 4'b0001);
    #2 reset = 1;
    #1;
    chk("async_state", 100, state, 4'b0001);
    chk("async_pop", 100, pop, 4'b0000);
    chk("async_valid", 100, {3'b000, valid_out}, 4'b0000);
    chk("async_sel", 100, {2'b00, sel}, 4'b0000);
    chk("async_idle", 100, {3'b000, idle}, 4'b0000);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_rr_ctrl.md
Name: fifo_rr_ctrl

Overview:
- Control block for a bank of NUM_REQ FIFOs.
- Drives the 4-bit one-hot `state` bus that every FIFO consumes: RESET 4'b0001, INIT 4'b0010, IDLE 4'b0100, ACTIVE 4'b1000.
- Distributes the almost-full and almost-empty thresholds to the FIFOs.
- Round-robin arbitrates pops from the non-empty FIFOs into one shared downstream consumer, with backpressure from that consumer.

Parameters:
- NUM_REQ, 4, number of FIFOs arbitrated; legal values 2..8.
- IDX_W, 2, width of the grant index; must be at least clog2(NUM_REQ).
- TH_W, 3, threshold width; matches the FIFO threshold inputs.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  configuration request; enters INIT and holds there while high.
- sup_th_in  in  TH_W  almost-full threshold to load.
- inf_th_in  in  TH_W  almost-empty threshold to load.
- empty  in  NUM_REQ  per-FIFO empty flags; bit i belongs to FIFO i.
- ds_alm_full  in  1  downstream almost-full (backpressure).
- state  out  4  one-hot FSM state broadcast to all FIFOs.
- sup_Threshold  out  TH_W  registered almost-full threshold to the FIFOs.
- inf_Threshold  out  TH_W  registered almost-empty threshold to the FIFOs.
- pop  out  NUM_REQ  one-hot pop strobes to the FIFOs; combinational.
- sel  out  IDX_W  registered index of the FIFO popped in the previous cycle.
- valid_out  out  1  registered; FIFO data on the output mux is valid this cycle.
- idle  out  1  high while state is IDLE.
- cfg_error  out  1  sticky; thresholds were illegal on INIT exit.

Behaviour:
- Reset:
  - reset high, asynchronous: state=4'b0001, thresholds=0, sel=0, valid_out=0, cfg_error=0, round-robin pointer = NUM_REQ-1, so FIFO 0 wins first.
  - pop=0 and idle=0 while reset is high.
- State transitions, evaluated at each rising edge:
  - RESET -> INIT on the first edge after reset deasserts. RESET always lasts at least one cycle with reset low.
  - INIT:
    - Latch sup_th_in/inf_th_in into sup_Threshold/inf_Threshold every cycle.
    - If init=0, go to IDLE. INIT lasts at least one cycle.
    - On exit, if sup_th_in <= inf_th_in: set cfg_error=1 and still go to IDLE.
    - cfg_error clears only on reset, or on the next INIT entry.
  - IDLE: init=1 -> INIT; otherwise any empty bit 0 -> ACTIVE; otherwise stay.
  - ACTIVE: init=1 -> INIT (priority); otherwise all empty bits 1 -> IDLE.
  - Reserved or illegal state encodings return to RESET.
- Arbitration (combinational, ACTIVE only):
  - Grant condition: ACTIVE, init=0 and ds_alm_full=0.
  - When granted, pop[g]=1 for the first i with empty[i]=0, scanning (ptr+1) mod NUM_REQ upward with wrap-around.
  - pop=0 in all other states, when init=1, or when ds_alm_full=1.
  - pop is never more than one-hot. pop[i] never asserts while empty[i]=1.
  - At the clock edge after a grant: ptr <= g.
- Output timing:
  - valid_out <= |pop, and sel <= g; both are one cycle behind pop, matching the FIFO memory read latency.
  - With no pop, valid_out <= 0 and sel holds.
- Backpressure: ds_alm_full=1 blocks pops in that same cycle; the pointer is not advanced.
- Mid-operation events:
  - Entering INIT or RESET forces pop=0 immediately.
  - A valid_out already registered still appears for one cycle.
  - The FIFO pointers reset only in RESET; the FIFOs reset their own pointers when state=4'b0001.
- Empty-flag timing: FIFO empty updates one cycle after a pop. A FIFO holding its last entry may be granted again in the following cycle. The FIFO ignores a pop while its count is 0, and valid_out is still raised. Downstream qualifies data on a nonzero word.

Optional Feature:
- Macro: FIFO_RR_CTRL_BURST_EN.
- Defined:
  - The current grantee keeps the grant for up to 4 consecutive granted cycles while its empty bit is 0.
  - A 2-bit burst counter counts the burst; the pointer advances only when the burst ends (count reaches 4, FIFO empty, or backpressure).
  - The counter resets to 0 on reset, on INIT, and whenever the grantee changes.
- Undefined: strict one-pop rotation as described above; no burst counter is present.

Test Plan:
- Reset/config: assert reset 3 cycles, release, hold init=1 with sup=6 and inf=2 for 2 cycles, then init=0 -> state sequence 0001, 0010, 0010, 0100; thresholds 6/2; cfg_error=0.
- Illegal config: init exit with sup=2 and inf=5 -> cfg_error=1 in IDLE. Re-init with 6/2 -> cfg_error=0.
- Round-robin: empty=4'b0000 for 8 cycles in ACTIVE -> pop sequence 0001, 0010, 0100, 1000, 0001...; sel follows one cycle later; valid_out=1 continuously.
- Skip and wrap: ptr=1 and empty=4'b1011 -> pop=0100. Then empty=4'b1110 -> pop=0001, wrapping past index 3.
- Backpressure/idle: ds_alm_full=1 for 3 cycles -> pop=0 and valid_out falls after 1 cycle, ptr unchanged. Then empty=4'b1111 -> ACTIVE goes to IDLE next edge and idle=1.
- Async reset mid-ACTIVE: reset raised between edges -> state=0001, pop=0 and valid_out=0 immediately, without waiting for clk.
- BURST_EN build: all FIFOs non-empty -> pop=0001 for 4 cycles, then 0010 for 4 cycles.
